ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
// Shares one AHB address/data bus (feeding AHB_bridge slaves) among NUM_MASTERS masters.
// - Round-robin grant; parks on DEFAULT_MASTER when no master requests.
// - Fixed-length bursts and locked sequences are never broken.
// - Drives the address-phase owner (h_master) and the data-phase owner (h_master_data) for the bus muxes.
// PARAMETERS
// NUM_MASTERS     4   number of requesting masters (2..8)
// DEFAULT_MASTER  0   parked master index at reset and when there are no requests
// MW              $clog2(NUM_MASTERS)   master index width (derived, not overridable)
// PORTS
// h_clk          in   1            bus clock
// h_reset        in   1            synchronous reset, active-high
// h_busreq       in   NUM_MASTERS  per-master bus request
// h_lock         in   NUM_MASTERS  per-master locked-access request
// h_trans        in   2            muxed h_trans of the current address owner (00 IDLE,01 BUSY,10 NONSEQ,11 SEQ)
// h_burst        in   3            muxed h_burst of the current address owner
// h_ready        in   1            bus h_ready (transfer completes)
// h_resp         in   1            bus error response (first error cycle has h_ready=0)
// h_grant        out  NUM_MASTERS  one-hot registered grant
// h_master       out  MW           address-phase owner (drives address/control mux)
// h_master_data  out  MW           data-phase owner (drives h_wdata mux / rdata routing)
// h_mastlock     out  1            current address phase is locked
// BEHAVIOUR
// Reset (sync, h_reset=1 at posedge):
// - h_grant = onehot(DEFAULT_MASTER); h_master = h_master_data = DEFAULT_MASTER.
// - h_mastlock = 0; state = ARB; rr_ptr = DEFAULT_MASTER; beat_cnt = 0.
// - Reset mid-burst or mid-lock abandons that burst/lock immediately.
// Handover: on every posedge with h_ready=1:
// - h_master <= index(h_grant), then h_master_data <= old h_master.
// - Nothing moves while h_ready=0.
// - Grant-to-address-ownership latency = 1 h_ready cycle.
// Round-robin pick:
// - First requester after rr_ptr, searched in increasing index with wrap from NUM_MASTERS-1 to 0.
// - rr_ptr <= winner whenever the grant changes.
// - No requester -> DEFAULT_MASTER.
// FSM states ARB / BURST / LOCK. Everything below is evaluated at a posedge with h_ready=1 unless noted.
// ARB:
// - h_grant <= pick.
// - If the owner issues NONSEQ with a fixed burst -> load beat_cnt = len-1, go to BURST.
//   - len = 4/8/16 for WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16.
// - If the owner issues NONSEQ/SEQ with INCR and h_busreq[owner]=1 -> hold grant.
// - If h_lock[owner]=1 -> go to LOCK and hold grant.
// BURST: h_grant held.
// - SEQ: beat_cnt--.
// - BUSY: no change.
// - beat_cnt reaches 0, or owner issues IDLE -> ARB.
// - New NONSEQ reloads the count.
// - h_resp=1 with h_ready=0 (first error cycle) -> ARB at that edge; the burst is cancelled.
// LOCK: h_grant held regardless of other requests, including across error responses.
// - Exit to ARB on the first h_ready edge with h_lock[owner]=0.
// h_mastlock <= h_lock[index(h_grant)] on h_ready; the address phase it qualifies aligns with h_master.
// Simultaneous requests: only the round-robin order decides; no fixed priority.
// Requester drops h_busreq while granted in ARB: re-pick on the next h_ready edge.
// SINGLE bursts never leave ARB.
// TESTING
// T1: reset, no requests -> h_grant=0001, h_master=0; then h_busreq=0100 -> h_grant=0100 after 1 edge, h_master=2 after next h_ready edge.
// T2: masters 0,1,3 request continuously with SINGLE NONSEQs, h_ready=1 -> grant order 1,3,0,1,3,...
// T3: m1 INCR8 burst (NONSEQ+7 SEQ) with m2 requesting; 3 BUSY cycles inserted mid-burst -> h_grant stays 0010 for all 8 beats plus the BUSYs; 0100 on the edge after the 8th address.
// T4: m0 INCR16 burst; at beat 5 slave drives h_resp=1,h_ready=0 then h_resp=1,h_ready=1 -> arbiter returns to ARB; m3 granted on the first error edge.
// T5: m2 h_lock=1 for 3 NONSEQ transfers, m0/m1 requesting; ready wait-stated 2 cycles -> h_mastlock=1, grant held, released after h_lock drops.
// T6: h_reset pulsed during m1 WRAP8 beat 3 -> all outputs return to reset values on that edge; beat_cnt=0.

Source files
------------

// File: rtl/ahb_bus_arbiter_if.sv
// Bundle of request, transfer-control and grant signals between the AHB
// masters/bus muxes and the arbiter. The arbiter connects through the slave
// modport. The requesting side (masters plus the muxed bus) uses the master
// modport.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int MW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] h_busreq;
    logic [NUM_MASTERS-1:0] h_lock;
    logic [1:0]             h_trans;
    logic [2:0]             h_burst;
    logic                   h_ready;
    logic                   h_resp;
    logic [NUM_MASTERS-1:0] h_grant;
    logic [MW-1:0]          h_master;
    logic [MW-1:0]          h_master_data;
    logic                   h_mastlock;

    modport slave (
        input  h_busreq, h_lock, h_trans, h_burst, h_ready, h_resp,
        output h_grant, h_master, h_master_data, h_mastlock
    );

    modport master (
        output h_busreq, h_lock, h_trans, h_burst, h_ready, h_resp,
        input  h_grant, h_master, h_master_data, h_mastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter.
// - When nobody requests the bus, the grant parks on DEFAULT_MASTER.
// - Fixed-length bursts are never split.
// - INCR bursts are not split while the owner keeps h_busreq high.
// - Locked sequences are never split.
// - "Owner" means the master that currently holds the grant. The muxed
//   h_trans/h_burst are read as that master's transfer intent.
// - h_master follows the grant one h_ready edge later.
// - h_master_data follows h_master one h_ready edge after that.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic              h_clk,
    input  logic              h_reset,
    ahb_bus_arbiter_if.slave  bus
);
    localparam int MW = $clog2(NUM_MASTERS);
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_INCR   = 3'b001;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BURST = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             beat_cnt_q, beat_cnt_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [MW-1:0]          gnt_idx_q, gnt_idx_d;
    logic [NUM_MASTERS-1:0] h_grant_q, h_grant_d;
    logic [MW-1:0]          h_master_q, h_master_d;
    logic [MW-1:0]          h_master_data_q, h_master_data_d;
    logic                   h_mastlock_q, h_mastlock_d;

    // Round-robin candidates: slot gi is the master gi+1 places after rr_ptr
    logic [MW-1:0]          cand_idx [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] cand_req;
    logic [MW-1:0]          pick_idx;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
        assign cand_idx[gi] = MW'((int'(rr_ptr_q) + gi + 1) % NUM_MASTERS);
        assign cand_req[gi] = bus.h_busreq[cand_idx[gi]];
    end

    // Earliest requesting slot after rr_ptr wins; park on default when idle
    always_comb begin
        pick_idx = DEF_IDX;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                pick_idx = cand_idx[i];
            end
        end
    end

    // One-hot decode of the next grant index
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_onehot
        assign h_grant_d[gi] = (gnt_idx_d == MW'(gi));
    end

    // Number of beats still to come after the NONSEQ of a fixed-length burst
    function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
        case (hburst)
            3'd2, 3'd3: return 4'd3;
            3'd4, 3'd5: return 4'd7;
            3'd6, 3'd7: return 4'd15;
            default:    return 4'd0;
        endcase
    endfunction

    logic owner_req;
    logic owner_lock;
    logic fixed_burst;
    logic regrant;

    assign owner_req   = bus.h_busreq[gnt_idx_q];
    assign owner_lock  = bus.h_lock[gnt_idx_q];
    assign fixed_burst = (bus.h_burst[2:1] != 2'b00);

    // Next-state logic: FSM transitions, beat counting, handover pipeline
    always_comb begin
        state_d         = state_q;
        beat_cnt_d      = beat_cnt_q;
        rr_ptr_d        = rr_ptr_q;
        gnt_idx_d       = gnt_idx_q;
        h_master_d      = h_master_q;
        h_master_data_d = h_master_data_q;
        h_mastlock_d    = h_mastlock_q;
        regrant         = 1'b0;

        if (bus.h_ready) begin
            h_master_d      = gnt_idx_q;
            h_master_data_d = h_master_q;
            h_mastlock_d    = owner_lock;
            unique case (state_q)
                ST_ARB: begin
                    if (owner_lock) begin
                        state_d = ST_LOCK;
                    end else if (bus.h_trans == TR_NONSEQ && fixed_burst) begin
                        state_d    = ST_BURST;
                        beat_cnt_d = burst_beats_m1(bus.h_burst);
                    end else if (!((bus.h_trans == TR_NONSEQ || bus.h_trans == TR_SEQ)
                                   && bus.h_burst == HB_INCR && owner_req)) begin
                        regrant = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (bus.h_trans == TR_IDLE) begin
                        state_d    = ST_ARB;
                        beat_cnt_d = 4'd0;
                        regrant    = 1'b1;
                    end else if (bus.h_trans == TR_NONSEQ) begin
                        if (fixed_burst) begin
                            beat_cnt_d = burst_beats_m1(bus.h_burst);
                        end else begin
                            state_d    = ST_ARB;
                            beat_cnt_d = 4'd0;
                            regrant    = 1'b1;
                        end
                    end else if (bus.h_trans == TR_SEQ) begin
                        if (beat_cnt_q <= 4'd1) begin
                            state_d    = ST_ARB;
                            beat_cnt_d = 4'd0;
                            regrant    = 1'b1;
                        end else begin
                            beat_cnt_d = beat_cnt_q - 4'd1;
                        end
                    end
                    // BUSY: the burst is paused, nothing changes
                end
                ST_LOCK: begin
                    if (!owner_lock) begin
                        state_d = ST_ARB;
                        regrant = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_ARB;
                end
            endcase
        end else if (bus.h_resp && state_q == ST_BURST) begin
            // First error cycle: cancel the burst and re-arbitrate immediately
            state_d    = ST_ARB;
            beat_cnt_d = 4'd0;
            regrant    = 1'b1;
        end

        if (regrant && pick_idx != gnt_idx_q) begin
            gnt_idx_d = pick_idx;
            rr_ptr_d  = pick_idx;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge h_clk) begin
        if (h_reset) begin
            state_q         <= ST_ARB;
            beat_cnt_q      <= 4'd0;
            rr_ptr_q        <= DEF_IDX;
            gnt_idx_q       <= DEF_IDX;
            h_grant_q       <= NUM_MASTERS'(1) << DEFAULT_MASTER;
            h_master_q      <= DEF_IDX;
            h_master_data_q <= DEF_IDX;
            h_mastlock_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            beat_cnt_q      <= beat_cnt_d;
            rr_ptr_q        <= rr_ptr_d;
            gnt_idx_q       <= gnt_idx_d;
            h_grant_q       <= h_grant_d;
            h_master_q      <= h_master_d;
            h_master_data_q <= h_master_data_d;
            h_mastlock_q    <= h_mastlock_d;
        end
    end

    assign bus.h_grant       = h_grant_q;
    assign bus.h_master      = h_master_q;
    assign bus.h_master_data = h_master_data_q;
    assign bus.h_mastlock    = h_mastlock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed testbench for ahb_bus_arbiter (4 masters, parked on master 0).
// A transaction-level model predicts grant/ownership every cycle.
// Literal expectations pin the key scenarios.
module tb_ahb_bus_arbiter;
    localparam int N   = 4;
    localparam int DEF = 0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] WRAP8  = 3'd4;
    localparam logic [2:0] INCR8  = 3'd5;
    localparam logic [2:0] INCR16 = 3'd7;

    logic h_clk = 1'b0;
    logic h_reset;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;

    ahb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

    ahb_bus_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
        .h_clk   (h_clk),
        .h_reset (h_reset),
        .bus     (bus)
    );

    always #5 h_clk = ~h_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // mode: 0 = free arbitration, 1 = fixed burst in progress, 2 = locked
    int m_grant, m_master, m_data, m_lock, m_ptr, m_mode, m_done, m_total;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return DEF;
    endfunction

    function automatic int beats_of(input logic [2:0] b);
        if (b == 3'd2 || b == 3'd3) return 4;
        if (b == 3'd4 || b == 3'd5) return 8;
        if (b == 3'd6 || b == 3'd7) return 16;
        return 1;
    endfunction

    always @(posedge h_clk) begin : model
        bit rearb;
        int w;
        rearb = 1'b0;
        if (h_reset) begin
            m_grant = DEF; m_master = DEF; m_data = DEF; m_lock = 0;
            m_ptr = DEF; m_mode = 0; m_done = 0; m_total = 0;
        end else if (bus.h_ready) begin
            m_data   = m_master;
            m_master = m_grant;
            m_lock   = int'(bus.h_lock[m_grant]);
            if (m_mode == 0) begin
                if (bus.h_lock[m_grant]) m_mode = 2;
                else if (bus.h_trans == NONSEQ && beats_of(bus.h_burst) > 1) begin
                    m_mode = 1; m_done = 1; m_total = beats_of(bus.h_burst);
                end else if ((bus.h_trans == NONSEQ || bus.h_trans == SEQ) &&
                             bus.h_burst == INCR && bus.h_busreq[m_grant]) begin
                    // INCR owner keeps the bus while still requesting
                end else rearb = 1'b1;
            end else if (m_mode == 1) begin
                if (bus.h_trans == IDLE) begin
                    m_mode = 0; rearb = 1'b1;
                end else if (bus.h_trans == NONSEQ) begin
                    if (beats_of(bus.h_burst) > 1) begin
                        m_done = 1; m_total = beats_of(bus.h_burst);
                    end else begin
                        m_mode = 0; rearb = 1'b1;
                    end
                end else if (bus.h_trans == SEQ) begin
                    m_done++;
                    if (m_done >= m_total) begin
                        m_mode = 0; rearb = 1'b1;
                    end
                end
            end else begin
                if (!bus.h_lock[m_grant]) begin
                    m_mode = 0; rearb = 1'b1;
                end
            end
        end else if (bus.h_resp && m_mode == 1) begin
            m_mode = 0; rearb = 1'b1;
        end
        if (rearb) begin
            w = rr_pick(m_ptr, bus.h_busreq);
            if (w != m_grant) begin
                m_grant = w; m_ptr = w;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(posedge h_clk) begin
        #2;
        if (chk_en) begin
            chk("model_grant",    bus.h_grant,       32'(1) << m_grant);
            chk("model_master",   bus.h_master,      m_master);
            chk("model_data",     bus.h_master_data, m_data);
            chk("model_mastlock", bus.h_mastlock,    m_lock);
        end
    end

    // One bus cycle: drive inputs at negedge, return just after the next posedge
    task automatic step(input logic [N-1:0] req, input logic [N-1:0] lck, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rdy, input logic rsp, input logic rst);
        @(negedge h_clk);
        bus.h_busreq = req; bus.h_lock = lck; bus.h_trans = tr; bus.h_burst = bu;
        bus.h_ready = rdy; bus.h_resp = rsp; h_reset = rst;
        @(posedge h_clk);
        #3;
        $display("t=%0t rst=%b req=%b lock=%b trans=%0d burst=%0d rdy=%b resp=%b -> grant=%b master=%0d data=%0d mastlock=%b",
                 $time, rst, req, lck, tr, bu, rdy, rsp, bus.h_grant, bus.h_master,
                 bus.h_master_data, bus.h_mastlock);
    endtask

    task automatic do_reset();
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 1'b1);
    endtask

    logic [3:0] t2_exp [5];
    logic [1:0] t3_tr  [9];

    initial begin
        bus.h_busreq = '0; bus.h_lock = '0; bus.h_trans = IDLE; bus.h_burst = SINGLE;
        bus.h_ready = 1'b1; bus.h_resp = 1'b0; h_reset = 1'b1;

        // T1: reset, park, single requester
        do_reset();
        chk_en = 1'b1;
        do_reset();
        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 1'b0);
        chk("t1_park_grant", bus.h_grant, 4'b0001);
        chk("t1_park_master", bus.h_master, 0);
        chk("t1_park_data", bus.h_master_data, 0);
        chk("t1_park_lock", bus.h_mastlock, 0);
        step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 1'b0);
        chk("t1_grant_m2", bus.h_grant, 4'b0100);
        chk("t1_master_still0", bus.h_master, 0);
        step(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 1'b0);
        chk("t1_master_m2", bus.h_master, 2);

        // T2: round-robin among masters 0,1,3
        do_reset();
        t2_exp = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            step(4'b1011, 4'b0000, NONSEQ, SINGLE, 1'b1, 1'b0, 1'b0);
            chk($sformatf("t2_rr_%0d", i), bus.h_grant, t2_exp[i]);
        end

        // T3: m1 INCR8 with BUSYs, m2 waiting
        do_reset();
        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 1'b0);
        chk("t3_grant_m1", bus.h_grant, 4'b0010);
        step(4'b0110, 4'b0000, NONSEQ, INCR8, 1'b1, 1'b0, 1'b0);
        chk("t3_nonseq_hold", bus.h_grant, 4'b0010);
        t3_tr = '{SEQ, SEQ, BUSY, BUSY, BUSY, SEQ, SEQ, SEQ, SEQ};
        for (int i = 0; i < 9; i++) begin
            step(4'b0110, 4'b0000, t3_tr[i], INCR8, 1'b1, 1'b0, 1'b0);
            chk($sformatf("t3_hold_%0d", i), bus.h_grant, 4'b0010);
        end
        step(4'b0110, 4'b0000, SEQ, INCR8, 1'b1, 1'b0, 1'b0);
        chk("t3_release_m2", bus.h_grant, 4'b0100);

        // T4: m0 INCR16 hit by an ERROR at beat 5, m3 waiting
        do_reset();
        step(4'b1001, 4'b0000, NONSEQ, INCR16, 1'b1, 1'b0, 1'b0);
        chk("t4_burst_start", bus.h_grant, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            step(4'b1001, 4'b0000, SEQ, INCR16, 1'b1, 1'b0, 1'b0);
            chk($sformatf("t4_hold_%0d", i), bus.h_grant, 4'b0001);
        end
        step(4'b1001, 4'b0000, SEQ, INCR16, 1'b0, 1'b1, 1'b0);
        chk("t4_err_grant_m3", bus.h_grant, 4'b1000);
        chk("t4_err_master_frozen", bus.h_master, 0);
        step(4'b1001, 4'b0000, IDLE, SINGLE, 1'b1, 1'b1, 1'b0);
        chk("t4_master_m3", bus.h_master, 3);
        chk("t4_grant_m0", bus.h_grant, 4'b0001);

        // T5: m2 locked sequence with wait states, m0/m1 requesting
        do_reset();
        step(4'b0100, 4'b0100, IDLE, SINGLE, 1'b1, 1'b0, 1'b0);
        chk("t5_grant_m2", bus.h_grant, 4'b0100);
        step(4'b0111, 4'b0100, NONSEQ, SINGLE, 1'b1, 1'b0, 1'b0);
        chk("t5_lock_grant", bus.h_grant, 4'b0100);
        chk("t5_mastlock", bus.h_mastlock, 1);
        chk("t5_master_m2", bus.h_master, 2);
        for (int i = 0; i < 4; i++) begin
            step(4'b0111, 4'b0100, NONSEQ, SINGLE, (i >= 2), 1'b0, 1'b0);
            chk($sformatf("t5_hold_%0d", i), bus.h_grant, 4'b0100);
        end
        step(4'b0011, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 1'b0);
        chk("t5_release_grant", bus.h_grant, 4'b0001);
        chk("t5_release_mastlock", bus.h_mastlock, 0);

        // T6: reset in the middle of an m1 WRAP8 burst
        do_reset();
        step(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 1'b0);
        step(4'b0110, 4'b0000, NONSEQ, WRAP8, 1'b1, 1'b0, 1'b0);
        step(4'b0110, 4'b0000, SEQ, WRAP8, 1'b1, 1'b0, 1'b0);
        step(4'b0110, 4'b0000, SEQ, WRAP8, 1'b1, 1'b0, 1'b1);
        chk("t6_rst_grant", bus.h_grant, 4'b0001);
        chk("t6_rst_master", bus.h_master, 0);
        chk("t6_rst_data", bus.h_master_data, 0);
        chk("t6_rst_mastlock", bus.h_mastlock, 0);
        step(4'b0110, 4'b0000, SEQ, WRAP8, 1'b1, 1'b0, 1'b0);
        chk("t6_after_m1", bus.h_grant, 4'b0010);
        step(4'b0110, 4'b0000, SEQ, WRAP8, 1'b1, 1'b0, 1'b0);
        chk("t6_burst_abandoned", bus.h_grant, 4'b0100);

        // T7: INCR held while requesting, re-picked when the request drops
        do_reset();
        step(4'b0011, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 1'b0);
        chk("t7_grant_m1", bus.h_grant, 4'b0010);
        step(4'b0011, 4'b0000, NONSEQ, INCR, 1'b1, 1'b0, 1'b0);
        chk("t7_incr_hold0", bus.h_grant, 4'b0010);
        step(4'b0011, 4'b0000, SEQ, INCR, 1'b1, 1'b0, 1'b0);
        chk("t7_incr_hold1", bus.h_grant, 4'b0010);
        step(4'b0001, 4'b0000, SEQ, INCR, 1'b1, 1'b0, 1'b0);
        chk("t7_drop_repick", bus.h_grant, 4'b0001);

        step(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
